// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
// Multi-cycle Moore control unit for the single-datapath CPU. Each instruction
// walks FETCH -> DECODE -> (execute / memory / compare) -> BRANCH or PCINC, and
// only one instruction is in flight at a time. The opcode and func fields are
// captured on the edge that leaves DECODE. Every later state uses only those
// captured copies, so instr may change once DECODE is over.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (state, latched fields, outputs)
//   instr[31:0]    fetched instruction word, opcode [31:26], func [3:0]
//   zero           ALU zero flag, only looked at while leaving CMP
//   PC_sel         0 = PC+4, 1 = PC+4+immed
//   PC_lden        PC load enable
//   rf_wren        register-file write enable
//   rf_wrdata_sel  0 = ALU result, 1 = memory data
//   rf_b_sel       0 = instr[15:11], 1 = instr[20:16] on read port B
//   ALU_bin_sel    0 = rfB, 1 = immed
//   ALU_func[3:0]  0000 add, 0001 sub, 0010 and, 0011 or, else R-type func
//   MEM_wren       data-memory write enable
//   state[3:0]     current state code (debug)
//   instr_done     one-cycle pulse in the last cycle of each instruction
module cpu_control_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   output logic        PC_sel,
   output logic        PC_lden,
   output logic        rf_wren,
   output logic        rf_wrdata_sel,
   output logic        rf_b_sel,
   output logic        ALU_bin_sel,
   output logic [3:0]  ALU_func,
   output logic        MEM_wren,
   output logic [3:0]  state,
   output logic        instr_done
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_ALUWB  = 4'd3,
      S_ADDR   = 4'd4,
      S_MEMRD  = 4'd5,
      S_LDWB   = 4'd6,
      S_MEMWR  = 4'd7,
      S_CMP    = 4'd8,
      S_BRANCH = 4'd9,
      S_PCINC  = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b100000;
   localparam logic [5:0] OP_ADDI  = 6'b110000;
   localparam logic [5:0] OP_ANDI  = 6'b110010;
   localparam logic [5:0] OP_ORI   = 6'b110011;
   localparam logic [5:0] OP_LW    = 6'b001111;
   localparam logic [5:0] OP_SW    = 6'b011111;
   localparam logic [5:0] OP_B     = 6'b111111;
   localparam logic [5:0] OP_BEQ   = 6'b000000;
   localparam logic [5:0] OP_BNE   = 6'b000001;

   typedef struct packed {
      logic       pc_sel;
      logic       pc_lden;
      logic       rf_wren;
      logic       rf_wrdata_sel;
      logic       rf_b_sel;
      logic       alu_bin_sel;
      logic [3:0] alu_func;
      logic       mem_wren;
      logic       instr_done;
   } ctrl_t;

   // ALU operation used by EXEC/ALUWB for the register and immediate ALU ops.
   function automatic logic [3:0] alu_func_for(input logic [5:0] op, input logic [3:0] func);
      logic [3:0] f;
      case (op)
         OP_RTYPE: f = func;
         OP_ANDI:  f = 4'b0010;
         OP_ORI:   f = 4'b0011;
         default:  f = 4'b0000;
      endcase
      return f;
   endfunction

   // Moore output decode: strobes as a function of a state and the latched fields.
   function automatic ctrl_t ctrl_for(input state_t st, input logic [5:0] op, input logic [3:0] func);
      ctrl_t c;
      c = '0;
      case (st)
         S_EXEC, S_ALUWB: begin
            c.alu_bin_sel   = (op != OP_RTYPE);
            c.alu_func      = alu_func_for(op, func);
            c.rf_wren       = (st == S_ALUWB);
            c.rf_wrdata_sel = 1'b0;
         end
         S_ADDR, S_MEMRD, S_LDWB, S_MEMWR: begin
            c.rf_b_sel      = 1'b1;
            c.alu_bin_sel   = 1'b1;
            c.alu_func      = 4'b0000;
            c.rf_wren       = (st == S_LDWB);
            c.rf_wrdata_sel = (st == S_LDWB);
            c.mem_wren      = (st == S_MEMWR);
         end
         S_CMP: begin
            c.rf_b_sel    = 1'b1;
            c.alu_bin_sel = 1'b0;
            c.alu_func    = 4'b0001;
         end
         S_BRANCH: begin
            c.pc_lden    = 1'b1;
            c.pc_sel     = 1'b1;
            c.instr_done = 1'b1;
         end
         S_PCINC: begin
            c.pc_lden    = 1'b1;
            c.pc_sel     = 1'b0;
            c.instr_done = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t     state_r, next_state_s;
   logic [5:0] op_r, op_nxt_s;
   logic [3:0] func_r, func_nxt_s;
   ctrl_t      ctrl_r, ctrl_nxt_s;

   // Operand and immediate fields are handled by the datapath, not here.
   logic       instr_unused_s;
   assign instr_unused_s = ^instr[25:4];

   // Next-state, next-field and next-output decode.
   always_comb begin
      next_state_s = S_FETCH;
      op_nxt_s     = op_r;
      func_nxt_s   = func_r;
      case (state_r)
         S_FETCH:  next_state_s = S_DECODE;
         S_DECODE: begin
            // Decoding here uses the live word, which is what gets latched.
            op_nxt_s   = instr[31:26];
            func_nxt_s = instr[3:0];
            case (instr[31:26])
               OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: next_state_s = S_EXEC;
               OP_LW, OP_SW:                       next_state_s = S_ADDR;
               OP_B:                               next_state_s = S_BRANCH;
               OP_BEQ, OP_BNE:                     next_state_s = S_CMP;
               default:                            next_state_s = S_PCINC;
            endcase
         end
         S_EXEC:   next_state_s = S_ALUWB;
         S_ALUWB:  next_state_s = S_PCINC;
         S_ADDR: begin
            if (op_r == OP_LW) begin
               next_state_s = S_MEMRD;
            end else if (op_r == OP_SW) begin
               next_state_s = S_MEMWR;
            end else begin
               next_state_s = S_PCINC;
            end
         end
         S_MEMRD:  next_state_s = S_LDWB;
         S_LDWB:   next_state_s = S_PCINC;
         S_MEMWR:  next_state_s = S_PCINC;
         S_CMP: begin
            if (((op_r == OP_BEQ) && zero) || ((op_r == OP_BNE) && !zero)) begin
               next_state_s = S_BRANCH;
            end else begin
               next_state_s = S_PCINC;
            end
         end
         S_BRANCH: next_state_s = S_FETCH;
         S_PCINC:  next_state_s = S_FETCH;
         default:  next_state_s = S_FETCH;
      endcase
      // Outputs are registered, so decode them from the state being entered.
      ctrl_nxt_s = ctrl_for(next_state_s, op_nxt_s, func_nxt_s);
   end

   // State, latched fields and registered strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_FETCH;
         op_r    <= 6'b000000;
         func_r  <= 4'b0000;
         ctrl_r  <= '0;
      end else begin
         state_r <= next_state_s;
         op_r    <= op_nxt_s;
         func_r  <= func_nxt_s;
         ctrl_r  <= ctrl_nxt_s;
      end
   end

   assign PC_sel        = ctrl_r.pc_sel;
   assign PC_lden       = ctrl_r.pc_lden;
   assign rf_wren       = ctrl_r.rf_wren;
   assign rf_wrdata_sel = ctrl_r.rf_wrdata_sel;
   assign rf_b_sel      = ctrl_r.rf_b_sel;
   assign ALU_bin_sel   = ctrl_r.alu_bin_sel;
   assign ALU_func      = ctrl_r.alu_func;
   assign MEM_wren      = ctrl_r.mem_wren;
   assign instr_done    = ctrl_r.instr_done;
   assign state         = state_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Testbench for cpu_control_fsm. Stimulus pushes one expected output word per
// cycle into a queue. A separate monitor pops a word on every falling edge,
// and on demand for asynchronous checks, and compares it with the DUT.
module tb_cpu_control_fsm;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic        zero;
   logic        PC_sel, PC_lden, rf_wren, rf_wrdata_sel, rf_b_sel, ALU_bin_sel;
   logic [3:0]  ALU_func;
   logic        MEM_wren;
   logic [3:0]  state;
   logic        instr_done;

   cpu_control_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .instr         (instr),
      .zero          (zero),
      .PC_sel        (PC_sel),
      .PC_lden       (PC_lden),
      .rf_wren       (rf_wren),
      .rf_wrdata_sel (rf_wrdata_sel),
      .rf_b_sel      (rf_b_sel),
      .ALU_bin_sel   (ALU_bin_sel),
      .ALU_func      (ALU_func),
      .MEM_wren      (MEM_wren),
      .state         (state),
      .instr_done    (instr_done)
   );

   // Word layout: {state, PC_sel, PC_lden, rf_wren, rf_wrdata_sel, rf_b_sel,
   //               ALU_bin_sel, ALU_func, MEM_wren, instr_done}
   logic [15:0] exp_q[$];
   int          n_cmp;
   int          n_mis;
   logic        drain_chk;
   event        chk_ev;

   localparam logic [31:0] I_ADDI  = 32'hC000_0007;
   localparam logic [31:0] I_RFUNC = 32'h8000_FFF1;
   localparam logic [31:0] I_LW    = 32'h3C00_0000;
   localparam logic [31:0] I_SW    = 32'h7C00_0000;
   localparam logic [31:0] I_BEQ   = 32'h0000_0000;
   localparam logic [31:0] I_BNE   = 32'h0400_0000;
   localparam logic [31:0] I_B     = 32'hFC00_0000;
   localparam logic [31:0] I_ILL   = 32'hA800_0000;
   localparam logic [31:0] I_ORI   = 32'hCC00_0005;
   localparam logic [31:0] I_ANDI  = 32'hC800_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ev(input int st, input int pcs, input int pcl, input int rfw,
                                      input int wds, input int bs, input int bin, input int fn,
                                      input int mw, input int dn);
      logic [3:0] s4;
      logic [3:0] f4;
      s4 = st[3:0];
      f4 = fn[3:0];
      return {s4, pcs[0], pcl[0], rfw[0], wds[0], bs[0], bin[0], f4, mw[0], dn[0]};
   endfunction

   task automatic push(input logic [15:0] v);
      exp_q.push_back(v);
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic z, input int ncyc);
      instr = ins;
      zero  = z;
      repeat (ncyc) @(posedge clk);
      #1;
   endtask

   // Common vectors shared by several instructions.
   task automatic push_fd();
      push(ev(0, 0,0,0,0,0,0,0,0,0));
      push(ev(1, 0,0,0,0,0,0,0,0,0));
   endtask

   task automatic push_pcinc();
      push(ev(10, 0,1,0,0,0,0,0,0,1));
   endtask

   task automatic push_branch();
      push(ev(9, 1,1,0,0,0,0,0,0,1));
   endtask

   task automatic push_addi();
      push_fd();
      push(ev(2, 0,0,0,0,0,1,0,0,0));
      push(ev(3, 0,0,1,0,0,1,0,0,0));
      push_pcinc();
   endtask

   // Monitor: compares the DUT against the head of the expected queue.
   initial begin
      logic [15:0] exp_v;
      logic [15:0] act_v;
      forever begin
         @(negedge clk or chk_ev);
         if (drain_chk) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
               n_mis++;
               $display("FAIL drain: %0d expected vectors left unobserved, required 0", exp_q.size());
            end
         end else if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {state, PC_sel, PC_lden, rf_wren, rf_wrdata_sel, rf_b_sel,
                     ALU_bin_sel, ALU_func, MEM_wren, instr_done};
            n_cmp++;
            if (act_v !== exp_v) begin
               n_mis++;
               $display("FAIL vec%0d @%0t: got state=%0d ctrl=%03h, expected state=%0d ctrl=%03h",
                        n_cmp, $time, act_v[15:12], act_v[11:0], exp_v[15:12], exp_v[11:0]);
            end
         end
      end
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp     = 0;
      n_mis     = 0;
      drain_chk = 1'b0;
      reset     = 1'b0;
      instr     = I_ADDI;
      zero      = 1'b0;

      // Reset held for 3 cycles: everything 0, state FETCH.
      @(posedge clk);
      #1;
      repeat (3) push(ev(0, 0,0,0,0,0,0,0,0,0));
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // addi: 0,1,2,3,10, ALU_func 0000 despite nonzero low bits.
      push_addi();
      run_instr(I_ADDI, 1'b0, 5);

      // R-type with func 0001.
      push_fd();
      push(ev(2, 0,0,0,0,0,0,1,0,0));
      push(ev(3, 0,0,1,0,0,0,1,0,0));
      push_pcinc();
      run_instr(I_RFUNC, 1'b0, 5);

      // lw: 6 cycles, load write-back in LDWB only.
      push_fd();
      push(ev(4, 0,0,0,0,1,1,0,0,0));
      push(ev(5, 0,0,0,0,1,1,0,0,0));
      push(ev(6, 0,0,1,1,1,1,0,0,0));
      push_pcinc();
      run_instr(I_LW, 1'b0, 6);

      // sw: 5 cycles, one MEM_wren cycle.
      push_fd();
      push(ev(4, 0,0,0,0,1,1,0,0,0));
      push(ev(7, 0,0,0,0,1,1,0,1,0));
      push_pcinc();
      run_instr(I_SW, 1'b0, 5);

      // beq taken, beq not taken, bne not taken, bne taken.
      push_fd(); push(ev(8, 0,0,0,0,1,0,1,0,0)); push_branch();
      run_instr(I_BEQ, 1'b1, 4);
      push_fd(); push(ev(8, 0,0,0,0,1,0,1,0,0)); push_pcinc();
      run_instr(I_BEQ, 1'b0, 4);
      push_fd(); push(ev(8, 0,0,0,0,1,0,1,0,0)); push_pcinc();
      run_instr(I_BNE, 1'b1, 4);
      push_fd(); push(ev(8, 0,0,0,0,1,0,1,0,0)); push_branch();
      run_instr(I_BNE, 1'b0, 4);

      // Unconditional branch: 3 cycles.
      push_fd(); push_branch();
      run_instr(I_B, 1'b0, 3);

      // Illegal opcode 101010: 0,1,10 with no write strobes.
      push_fd(); push_pcinc();
      run_instr(I_ILL, 1'b0, 3);

      // ori: immediate OR.
      push_fd();
      push(ev(2, 0,0,0,0,0,1,3,0,0));
      push(ev(3, 0,0,1,0,0,1,3,0,0));
      push_pcinc();
      run_instr(I_ORI, 1'b0, 5);

      // andi, with instr switched to b after DECODE: latched andi must win.
      push_fd();
      push(ev(2, 0,0,0,0,0,1,2,0,0));
      push(ev(3, 0,0,1,0,0,1,2,0,0));
      push_pcinc();
      run_instr(I_ANDI, 1'b0, 2);
      run_instr(I_B, 1'b0, 3);

      // sw aborted by reset during MEMWR: strobe must drop at once.
      push_fd();
      push(ev(4, 0,0,0,0,1,1,0,0,0));
      push(ev(7, 0,0,0,0,1,1,0,1,0));
      run_instr(I_SW, 1'b0, 3);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      push(ev(0, 0,0,0,0,0,0,0,0,0));
      -> chk_ev;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Normal operation resumes after the abort.
      push_addi();
      run_instr(I_ADDI, 1'b0, 5);

      // Every pushed vector must have been consumed.
      drain_chk = 1'b1;
      -> chk_ev;
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control unit that sequences the single-datapath CPU: fetch, decode, execute, memory, write-back, PC update. It is a Moore state machine in the top level beside the datapath. It consumes the fetched instruction word and the ALU zero flag, and drives every datapath control strobe. One instruction completes per 3–6 cycles, with no overlap.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; clears the state register and latched fields
- instr  in  32  instruction word from the fetch stage; valid from the cycle after FETCH
- zero  in  1  ALU zero flag, combinational from the datapath
- PC_sel  out  1  0 = PC+4, 1 = PC+4+immed
- PC_lden  out  1  PC load enable
- rf_wren  out  1  register-file write enable
- rf_wrdata_sel  out  1  0 = ALU result, 1 = memory data
- rf_b_sel  out  1  0 = instr[15:11], 1 = instr[20:16] on read port B
- ALU_bin_sel  out  1  0 = rfB, 1 = immed
- ALU_func  out  4  0000 add, 0001 sub, 0010 and, 0011 or; others pass through from the R-type func field
- MEM_wren  out  1  data-memory write enable
- state  out  4  current state code (debug)
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
- Opcode is instr[31:26]; func is instr[3:0].
- Opcodes:
  - 100000: R-type
  - 110000: addi
  - 110010: andi
  - 110011: ori
  - 001111: lw
  - 011111: sw
  - 111111: b
  - 000000: beq
  - 000001: bne
  - Any other opcode is illegal and is treated as a nop.
- In DECODE, the controller latches op and func into internal registers. All later states use only these latched copies; instr may change after DECODE.
- Outputs are a pure function of the state and the latched op/func. Any output not listed for a state is 0.
- States and encoding:
  - FETCH (0): all outputs 0. Next is DECODE.
  - DECODE (1): latch fields. Next state:
    - R-type, addi, andi, ori → EXEC
    - lw, sw → ADDR
    - b → BRANCH
    - beq, bne → CMP
    - illegal → PCINC
  - EXEC (2): ALU_func = func for R-type; 0000 for addi, 0010 for andi, 0011 for ori. ALU_bin_sel = 1 for I-type, 0 for R-type. Next is ALUWB.
  - ALUWB (3): EXEC controls held, plus rf_wren = 1 and rf_wrdata_sel = 0. Next is PCINC.
  - ADDR (4): ALU_bin_sel = 1, ALU_func = 0000, rf_b_sel = 1. lw → MEMRD; sw → MEMWR.
  - MEMRD (5): ADDR controls held. Next is LDWB.
  - LDWB (6): ADDR controls held, plus rf_wren = 1 and rf_wrdata_sel = 1. Next is PCINC.
  - MEMWR (7): ADDR controls held, plus MEM_wren = 1. Next is PCINC.
  - CMP (8): rf_b_sel = 1, ALU_bin_sel = 0, ALU_func = 0001. Next is BRANCH if (beq & zero) | (bne & ~zero), otherwise PCINC.
  - BRANCH (9): PC_lden = 1, PC_sel = 1, instr_done = 1. Next is FETCH.
  - PCINC (10): PC_lden = 1, PC_sel = 0, instr_done = 1. Next is FETCH.
- Unused state codes 11–15 recover to FETCH on the next edge, with all outputs 0.
- Write strobes are exclusive: rf_wren, MEM_wren and PC_lden are never high in the same cycle.

## Timing
- Reset is asynchronous: reset = 0 forces state to FETCH immediately, sets every output to 0 and clears the latched op/func.
- The first state transition happens on the first rising edge after reset returns to 1.
- Reset asserted mid-instruction aborts the instruction with no further write strobes. A write strobe that coincides with reset assertion is dropped.
- Latency in cycles, FETCH through the PC-update state inclusive:
  - R-type and I-type ALU: 5
  - lw: 6
  - sw: 5
  - b: 3
  - beq/bne, taken or not: 4
  - illegal: 3
- zero is sampled only in CMP, on the edge that leaves CMP.
- The PC changes only at the edge ending BRANCH or PCINC, so instr stays stable from DECODE until FETCH.
- instr_done is high for exactly one cycle per instruction, coincident with PC_lden.

## Test plan
- Reset: hold reset = 0 for 3 cycles, then release with instr = addi → outputs all 0 and state = 0 during reset; state sequence 0,1,2,3,10,0.
- R-type: instr = {100000, …, func 0001} → ALU_func = 0001 and ALU_bin_sel = 0 in EXEC/ALUWB; rf_wren = 1 only in ALUWB; PC_lden at cycle 5.
- lw then sw:
  - lw: rf_wrdata_sel = 1 with rf_wren = 1 only in LDWB, 6 cycles total.
  - sw: MEM_wren = 1 for exactly one cycle with rf_b_sel = 1, ALU_bin_sel = 1, ALU_func = 0000, 5 cycles total.
- Branches:
  - beq with zero = 1 → BRANCH, PC_sel = 1.
  - beq with zero = 0 → PCINC, PC_sel = 0.
  - bne behaves inversely.
  - b takes 3 cycles with PC_sel = 1.
- Illegal opcode 101010 → states 0,1,10; no rf_wren or MEM_wren; instr_done pulses once.
- Mid-operation reset and instr change:
  - Pull reset low during MEMWR → MEM_wren drops to 0 asynchronously and state = 0.
  - Separately, change instr after DECODE → the sequence follows the latched opcode.
